reg_writeback_queue: RTL and testbench
======================================

REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

Interface
REQ-001 Parameters SHALL be: DBITS, default 32, data width; ABITS, default 4, register index width; DEPTH, default 4, queue entries (power of two, at least 2).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 inValid  input  1  write-request valid from the producer.
REQ-005 inReady  output  1  queue can accept a request this cycle.
REQ-006 inInd  input  ABITS  destination register index of the request.
REQ-007 inData  input  DBITS  write data of the request.
REQ-008 drainEn  input  1  register-file write port is available this cycle.
REQ-009 wrtEn  output  1  write enable to the register-file write port.
REQ-010 wrtInd  output  ABITS  write index to the register-file write port.
REQ-011 dIn  output  DBITS  write data to the register-file write port.
REQ-012 rdInd0, rdInd1  input  ABITS each  read indices being presented to the register file.
REQ-013 hit0, hit1  output  1 each  a pending entry matches rdInd0 / rdInd1.
REQ-014 fwd0, fwd1  output  DBITS each  forwarded data for rdInd0 / rdInd1.
REQ-015 count  output  clog2(DEPTH)+1  number of pending entries.

Function
REQ-016 The queue SHALL hold up to DEPTH {index, data} entries in FIFO order, using head and tail pointers that wrap modulo DEPTH.
REQ-017 inReady SHALL be 1 exactly when count < DEPTH; it SHALL NOT depend on drainEn, so there is no accept-when-full-with-pop.
REQ-018 A push SHALL occur at a clock edge where inValid and inReady are both 1: write {inInd, inData} at tail, tail+1. When inValid=1 and inReady=0, the request SHALL be ignored, and the producer holds it.
REQ-019 wrtEn SHALL be drainEn AND (count != 0), combinationally. wrtInd and dIn SHALL present the head entry whenever count != 0, and SHALL be 0 when the queue is empty.
REQ-020 A pop SHALL occur at a clock edge where wrtEn=1: head+1.
REQ-021 Push-to-drain latency SHALL be 1 cycle: an entry pushed at edge N is presented on wrtInd/dIn from edge N onward, so with drainEn=1 it is written at edge N+1.
REQ-022 Count update: push only gives +1; pop only gives -1; push and pop together leave count unchanged; neither leaves it unchanged.
REQ-023 Bypass SHALL be combinational: hitK=1 when any valid entry's index equals rdIndK. fwdK SHALL be the data of the youngest matching entry (closest to tail). When hitK=0, fwdK SHALL be 0.
REQ-024 Bypass SHALL include the head entry during the cycle it is being drained.
REQ-025 Bypass SHALL exclude a request being pushed in the same cycle.
REQ-026 Duplicate indices SHALL each be queued; there is no coalescing. Drain order SHALL equal push order.
REQ-027 The queue SHALL never overflow or underflow; pointers and count stay consistent under any input sequence.

Reset
REQ-028 While reset=1, asynchronously: head=0, tail=0, count=0. Consequently inReady=1, wrtEn=0, wrtInd=0, dIn=0, hit0=hit1=0, fwd0=fwd1=0.
REQ-029 Reset asserted mid-operation SHALL discard all pending entries, with no register-file write issued after assertion. Entry storage need not be cleared.
REQ-030 The first push SHALL be accepted at the first rising edge after reset deasserts.

Verification
REQ-031 Single write:
- Stimulus: after reset, push {3, 0xDEADBEEF} with drainEn=1.
- Response: the next cycle shows wrtEn=1, wrtInd=3, dIn=0xDEADBEEF; count returns to 0 one edge later.
REQ-032 Fill and stall:
- Stimulus: drainEn=0, push indices 1,2,3,4 (data 0x11..0x44), then attempt a 5th push.
- Response: count=4, inReady=0, 5th request not accepted. Then drainEn=1 gives writes 1,2,3,4 in order on consecutive cycles.
REQ-033 Youngest-wins bypass:
- Stimulus: drainEn=0, push {5,0xA}, then {5,0xB}; rdInd0=5, rdInd1=6.
- Response: hit0=1, fwd0=0xB, hit1=0, fwd1=0.
REQ-034 Simultaneous push and pop:
- Stimulus: count=2, drainEn=1, inValid=1 each cycle for 6 cycles.
- Response: count stays 2, six writes are issued in push order, and pointers wrap cleanly past DEPTH.
REQ-035 Reset mid-operation:
- Stimulus: count=3, assert reset between clock edges.
- Response: count=0, wrtEn=0, hit0=hit1=0 immediately. After release, only newly pushed entries are written.

Source files
------------

// File: rtl/reg_writeback_queue.sv
// Register write-back queue with read bypass; a push is on wrtInd/dIn the cycle after its edge.
// The queue holds inReady low while full, regardless of drainEn; drainEn stalls the write port.
module reg_writeback_queue #(
  parameter int DBITS = 32,
  parameter int ABITS = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [ABITS-1:0]           inInd,
  input  logic [DBITS-1:0]           inData,
  input  logic                       drainEn,
  output logic                       wrtEn,
  output logic [ABITS-1:0]           wrtInd,
  output logic [DBITS-1:0]           dIn,
  input  logic [ABITS-1:0]           rdInd0,
  input  logic [ABITS-1:0]           rdInd1,
  output logic                       hit0,
  output logic                       hit1,
  output logic [DBITS-1:0]           fwd0,
  output logic [DBITS-1:0]           fwd1,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PBITS = $clog2(DEPTH);
  localparam int CBITS = PBITS + 1;
  localparam logic [CBITS-1:0] FULL = CBITS'(DEPTH);

  typedef struct packed {
    logic [ABITS-1:0] ind;
    logic [DBITS-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PBITS-1:0] head;
  logic [PBITS-1:0] tail;
  logic [CBITS-1:0] cnt;
  logic             push;
  logic             pop;
  logic [PBITS-1:0] slot [DEPTH];
  logic             live [DEPTH];

  assign inReady = (cnt < FULL);
  assign push    = inValid && inReady;
  assign wrtEn   = drainEn && (cnt != '0);
  assign pop     = wrtEn;
  assign count   = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; validity comes only from head/count.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{ind: inInd, data: inData};
  end

  always_comb begin
    wrtInd = '0;
    dIn    = '0;
    if (cnt != '0) begin
      wrtInd = mem[head].ind;
      dIn    = mem[head].data;
    end
  end

  // Walk entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    fwd0 = '0;
    fwd1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot[i] = head + PBITS'(i);
      live[i] = (CBITS'(i) < cnt);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (mem[slot[i]].ind == rdInd0)) begin
        hit0 = 1'b1;
        fwd0 = mem[slot[i]].data;
      end
      if (live[i] && (mem[slot[i]].ind == rdInd1)) begin
        hit1 = 1'b1;
        fwd1 = mem[slot[i]].data;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: reset, drain latency, full stall, bypass, wrap, mid-run reset.
module tb_reg_writeback_queue;

  localparam int DBITS = 32;
  localparam int ABITS = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             inValid;
  logic             inReady;
  logic [ABITS-1:0] inInd;
  logic [DBITS-1:0] inData;
  logic             drainEn;
  logic             wrtEn;
  logic [ABITS-1:0] wrtInd;
  logic [DBITS-1:0] dIn;
  logic [ABITS-1:0] rdInd0;
  logic [ABITS-1:0] rdInd1;
  logic             hit0;
  logic             hit1;
  logic [DBITS-1:0] fwd0;
  logic [DBITS-1:0] fwd1;
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_writeback_queue #(.DBITS(DBITS), .ABITS(ABITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inValid(inValid), .inReady(inReady), .inInd(inInd), .inData(inData),
    .drainEn(drainEn), .wrtEn(wrtEn), .wrtInd(wrtInd), .dIn(dIn),
    .rdInd0(rdInd0), .rdInd1(rdInd1),
    .hit0(hit0), .hit1(hit1), .fwd0(fwd0), .fwd1(fwd1),
    .count(count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; return 1ns after it so sampling is away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ABITS-1:0] ind, input logic [DBITS-1:0] data);
    inValid = 1'b1;
    inInd   = ind;
    inData  = data;
    tick();
    inValid = 1'b0;
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    inValid = 1'b0;
    inInd   = '0;
    inData  = '0;
    drainEn = 1'b0;
    rdInd0  = '0;
    rdInd1  = '0;
    #3;
    check("rst_count",   count,   0);
    check("rst_inReady", inReady, 1);
    check("rst_wrtEn",   wrtEn,   0);
    check("rst_wrtInd",  wrtInd,  0);
    check("rst_dIn",     dIn,     0);
    check("rst_hit0",    hit0,    0);
    check("rst_hit1",    hit1,    0);
    check("rst_fwd0",    fwd0,    0);
    check("rst_fwd1",    fwd1,    0);
    tick();
    reset = 1'b0;
    #1;

    // Single write: first edge after reset accepts, next edge drains.
    drainEn = 1'b1;
    inValid = 1'b1;
    inInd   = 4'd3;
    inData  = 32'hDEADBEEF;
    #1;
    check("single_pre_wrtEn", wrtEn, 0);
    tick();
    inValid = 1'b0;
    #1;
    check("single_count1", count,  1);
    check("single_wrtEn",  wrtEn,  1);
    check("single_wrtInd", wrtInd, 3);
    check("single_dIn",    dIn,    32'hDEADBEEF);
    tick();
    check("single_count0", count, 0);
    check("single_idle",   wrtEn, 0);

    // Fill and stall.
    drainEn = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push(ABITS'(k), DBITS'(k * 32'h11));
      check($sformatf("fill_count%0d", k), count, k);
    end
    check("full_inReady", inReady, 0);
    rdInd0 = 4'd4;
    rdInd1 = 4'd1;
    #1;
    check("full_fwd0", fwd0, 32'h44);
    check("full_fwd1", fwd1, 32'h11);
    push(4'd5, 32'h55);
    check("stall_count", count, 4);
    drainEn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check($sformatf("drain%0d_wrtEn", k), wrtEn, 1);
      check($sformatf("drain%0d_wrtInd", k), wrtInd, k);
      check($sformatf("drain%0d_dIn", k), dIn, k * 32'h11);
      tick();
    end
    check("drain_empty", count, 0);
    check("drain_no5th", wrtEn, 0);

    // Youngest-wins bypass, excluded same-cycle push, head included while draining.
    drainEn = 1'b0;
    push(4'd5, 32'hA);
    push(4'd5, 32'hB);
    rdInd0 = 4'd5;
    rdInd1 = 4'd6;
    #1;
    check("yw_hit0", hit0, 1);
    check("yw_fwd0", fwd0, 32'hB);
    check("yw_hit1", hit1, 0);
    check("yw_fwd1", fwd1, 0);
    inValid = 1'b1;
    inInd   = 4'd5;
    inData  = 32'hC;
    #1;
    check("nopush_fwd0", fwd0, 32'hB);
    tick();
    inValid = 1'b0;
    #1;
    check("yw_fwd0_c", fwd0, 32'hC);
    check("yw_count3", count, 3);
    drainEn = 1'b1;
    tick();
    tick();
    check("head_drain_wrtEn", wrtEn, 1);
    check("head_drain_hit0",  hit0, 1);
    check("head_drain_fwd0",  fwd0, 32'hC);
    tick();
    check("yw_empty", count, 0);
    check("yw_hit_gone", hit0, 0);

    // Simultaneous push and pop across the pointer wrap.
    drainEn = 1'b0;
    push(4'd8, 32'h100);
    push(4'd9, 32'h101);
    drainEn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      inValid = 1'b1;
      inInd   = ABITS'(10 + k);
      inData  = 32'h102 + k;
      #1;
      check($sformatf("pp%0d_count", k), count, 2);
      check($sformatf("pp%0d_wrtInd", k), wrtInd, 8 + k);
      check($sformatf("pp%0d_dIn", k), dIn, 32'h100 + k);
      tick();
    end
    inValid = 1'b0;
    for (int k = 6; k < 8; k++) begin
      #1;
      check($sformatf("pp%0d_wrtInd", k), wrtInd, 8 + k);
      check($sformatf("pp%0d_dIn", k), dIn, 32'h100 + k);
      tick();
    end
    check("pp_empty", count, 0);

    // Reset between edges discards pending entries immediately.
    drainEn = 1'b0;
    push(4'd1, 32'h71);
    push(4'd2, 32'h72);
    push(4'd3, 32'h73);
    check("mr_count3", count, 3);
    rdInd0 = 4'd1;
    rdInd1 = 4'd3;
    drainEn = 1'b1;
    reset = 1'b1;
    #1;
    check("mr_count",   count,   0);
    check("mr_wrtEn",   wrtEn,   0);
    check("mr_hit0",    hit0,    0);
    check("mr_hit1",    hit1,    0);
    check("mr_inReady", inReady, 1);
    reset = 1'b0;
    #1;
    check("mr_post_wrtEn", wrtEn, 0);
    push(4'd7, 32'h77);
    check("mr_new_wrtInd", wrtInd, 7);
    check("mr_new_dIn",    dIn,    32'h77);
    check("mr_new_count",  count,  1);
    tick();
    check("mr_final_count", count, 0);
    check("mr_final_wrtEn", wrtEn, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
